// File: rtl/bp_packetizer.sv
// rtl/bp_packetizer.sv - groups responder bytes into USB bulk-IN packets
//
// Purpose: buffers bytes from the xoroshiro byte-pipe responder in a data FIFO,
// closes a packet when MAX_PKT bytes are pending or after TIMEOUT idle cycles,
// and replays committed packets as a data/valid/last stream.
//
// Ports:
//   i_clk        clock
//   i_rst        reset, asynchronous, active-high
//   i_cg         clock-gate enable; low => every register holds
//   i_bp_data    byte from responder
//   i_bp_valid   byte valid
//   o_bp_ready   byte accepted when valid && ready (combinational)
//   o_pkt_data   packet byte to endpoint
//   o_pkt_valid  o_pkt_data/last/empty valid
//   o_pkt_last   final beat of packet
//   o_pkt_empty  zero-length-packet marker
//   i_pkt_ready  endpoint accepts when valid && ready
//
// Optional feature: define BP_PACKETIZER_ZLP_EN to emit a zero-length packet
// when a full packet is followed by TIMEOUT idle cycles with no new byte.

module bp_packetizer #(
  parameter int MAX_PKT    = 64,
  parameter int DEPTH_LOG2 = 7,
  parameter int PKTQ_LOG2  = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cg,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready,
  output logic [7:0] o_pkt_data,
  output logic       o_pkt_valid,
  output logic       o_pkt_last,
  output logic       o_pkt_empty,
  input  logic       i_pkt_ready
);

  localparam int LW     = $clog2(MAX_PKT + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int QPW    = PKTQ_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int QDEPTH = 1 << PKTQ_LOG2;
  localparam logic [LW-1:0] MAX_L = LW'(MAX_PKT);
  localparam logic [TW-1:0] TO_C  = TW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [7:0]     fifo_mem [DEPTH];
  logic [LW-1:0]  pktq_mem [QDEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [QPW-1:0] q_wr, q_rd;
  logic [LW-1:0]  pending, pending_d;
  logic [TW-1:0]  idle, idle_d;
  logic [LW-1:0]  remaining, remaining_d, head_len, q_push_len;
  state_t         state, state_d;
  logic [7:0]     data_d;
  logic           valid_d, last_d, empty_d;
  logic           fifo_full, q_full, q_empty;
  logic           push, beat_acc, full_commit, zlp_commit, q_push, q_pop;
  logic           zlp_arm;

  // rd_ptr points at the byte held in the output register, so that byte still
  // occupies a FIFO slot until the endpoint takes it: capacity stays exactly
  // two full packets even while the output is stalled.
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign q_empty    = (q_wr == q_rd);
  assign q_full     = (q_wr[PKTQ_LOG2] != q_rd[PKTQ_LOG2]) &&
                      (q_wr[PKTQ_LOG2-1:0] == q_rd[PKTQ_LOG2-1:0]);

  assign o_bp_ready = !i_rst && !fifo_full && (pending != MAX_L);
  assign push       = i_cg && i_bp_valid && o_bp_ready;
  assign beat_acc   = i_cg && o_pkt_valid && i_pkt_ready;

  assign full_commit = i_cg && !q_full &&
                       ((pending == MAX_L) || (pending != '0 && idle == TO_C));

`ifdef BP_PACKETIZER_ZLP_EN
  assign zlp_commit = i_cg && !q_full && zlp_arm && (pending == '0) && (idle == TO_C);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      zlp_arm <= 1'b0;
    end else if (i_cg) begin
      if (push || zlp_commit) begin
        zlp_arm <= 1'b0;
      end else if (full_commit && pending == MAX_L) begin
        zlp_arm <= 1'b1;
      end
    end
  end
`else
  assign zlp_commit = 1'b0;
  assign zlp_arm    = 1'b0;
`endif

  assign q_push     = full_commit || zlp_commit;
  assign q_push_len = full_commit ? pending : '0;

  // Pending byte count and idle timer. A byte arriving in the commit cycle
  // starts the next packet. While armed for a ZLP the timer keeps running
  // with nothing pending.
  always_comb begin
    pending_d = pending;
    idle_d    = idle;
    if (q_push) begin
      pending_d = push ? LW'(1) : '0;
      idle_d    = '0;
    end else if (push) begin
      pending_d = pending + LW'(1);
      idle_d    = '0;
    end else if ((pending != '0 || zlp_arm) && idle != TO_C) begin
      idle_d = idle + TW'(1);
    end
  end

  // Emit FSM: the next byte is read from the slot after the one just taken.
  assign rd_next  = rd_ptr + PW'(beat_acc && !o_pkt_empty);
  assign head_len = pktq_mem[q_rd[PKTQ_LOG2-1:0]];

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    data_d      = o_pkt_data;
    valid_d     = o_pkt_valid;
    last_d      = o_pkt_last;
    empty_d     = o_pkt_empty;
    q_pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) q_pop = 1'b1;
      end
      S_SEND: begin
        if (beat_acc) begin
          if (remaining == LW'(1)) begin
            if (!q_empty) begin
              q_pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              empty_d = 1'b0;
            end
          end else begin
            remaining_d = remaining - LW'(1);
            data_d      = fifo_mem[rd_next[DEPTH_LOG2-1:0]];
            last_d      = (remaining == LW'(2));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (q_pop) begin
      state_d = S_SEND;
      valid_d = 1'b1;
      if (head_len == '0) begin
        remaining_d = LW'(1);
        data_d      = 8'h00;
        last_d      = 1'b1;
        empty_d     = 1'b1;
      end else begin
        remaining_d = head_len;
        data_d      = fifo_mem[rd_next[DEPTH_LOG2-1:0]];
        last_d      = (head_len == LW'(1));
        empty_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      pending     <= '0;
      idle        <= '0;
      state       <= S_IDLE;
      remaining   <= '0;
      o_pkt_data  <= 8'h00;
      o_pkt_valid <= 1'b0;
      o_pkt_last  <= 1'b0;
      o_pkt_empty <= 1'b0;
    end else if (i_cg) begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (q_push) q_wr   <= q_wr + QPW'(1);
      if (q_pop)  q_rd   <= q_rd + QPW'(1);
      rd_ptr      <= rd_next;
      pending     <= pending_d;
      idle        <= idle_d;
      state       <= state_d;
      remaining   <= remaining_d;
      o_pkt_data  <= data_d;
      o_pkt_valid <= valid_d;
      o_pkt_last  <= last_d;
      o_pkt_empty <= empty_d;
    end
  end

  // Storage arrays carry no reset; the pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (push)   fifo_mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_bp_data;
    if (q_push) pktq_mem[q_wr[PKTQ_LOG2-1:0]]    <= q_push_len;
  end

endmodule
